// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the MULTU/MULT shift-add sequencer: ALU op codes,
// controller state encoding and default operand width.
package mul_seq_ctrl_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_CORR_A = 3'd2,
      ST_CORR_B = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   // Counter wide enough to hold 0..w inclusive.
   function automatic int cnt_bits(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/mul_seq_ctrl_alu.sv
// Team ALU slice: AND/OR/ADD/SUB on W-bit operands with carry out
// (carry on SUB means no borrow).
module mul_seq_ctrl_alu
   import mul_seq_ctrl_pkg::*;
#(
   parameter int W = DATA_WIDTH_DEF
) (
   input  logic [2:0]   alu_op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] result,
   output logic         carry_out
);

   logic [W:0] sum;
   logic [W:0] dif;

   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      dif       = {1'b0, a} - {1'b0, b};
      result    = '0;
      carry_out = 1'b0;
      case (alu_op)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_ADD: {carry_out, result} = sum;
         ALU_SUB: begin
            result    = dif[W-1:0];
            carry_out = ~dif[W];
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-add multiplier sequencer sharing one ALU. Define MUL_SIGNED_EN to add
// the req_signed port and the two HI correction states for MULT.
module mul_seq_ctrl
   import mul_seq_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
`ifdef MUL_SIGNED_EN
   input  logic                  req_signed,
`endif
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_hi,
   output logic [DATA_WIDTH-1:0] resp_lo
);

   localparam int CW = cnt_bits(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

   state_t                state, state_nxt;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] mcand, acc, mplr;
   logic                  resp_valid_q;

`ifdef MUL_SIGNED_EN
   logic [DATA_WIDTH-1:0] bop;
   logic                  neg_a, neg_b, sgn_q;
`endif

   logic [2:0]            alu_op;
   logic [DATA_WIDTH-1:0] alu_b, alu_res;
   logic                  alu_co;
   logic                  step_c;
   logic [DATA_WIDTH-1:0] step_s;

   mul_seq_ctrl_alu #(.W(DATA_WIDTH)) u_alu (
      .alu_op    (alu_op),
      .a         (acc),
      .b         (alu_b),
      .result    (alu_res),
      .carry_out (alu_co)
   );

   always_comb begin
      state_nxt = state;
      alu_op    = ALU_ADD;
      alu_b     = mcand;
      case (state)
         ST_IDLE: if (req_valid) state_nxt = ST_RUN;
         ST_RUN: begin
            if (cnt == CNT_LAST) begin
`ifdef MUL_SIGNED_EN
               state_nxt = sgn_q ? ST_CORR_A : ST_DONE;
`else
               state_nxt = ST_DONE;
`endif
            end
         end
`ifdef MUL_SIGNED_EN
         // Two's-complement fixup on HI: subtract b if a<0, then a if b<0.
         ST_CORR_A: begin
            alu_op    = ALU_SUB;
            alu_b     = bop;
            state_nxt = ST_CORR_B;
         end
         ST_CORR_B: begin
            alu_op    = ALU_SUB;
            state_nxt = ST_DONE;
         end
`endif
         ST_DONE: if (resp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Add step result; skipped adds keep acc and force carry to 0.
   always_comb begin
      if (mplr[0]) {step_c, step_s} = {alu_co, alu_res};
      else         {step_c, step_s} = {1'b0, acc};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         mcand        <= '0;
         acc          <= '0;
         mplr         <= '0;
         resp_valid_q <= 1'b0;
`ifdef MUL_SIGNED_EN
         bop          <= '0;
         neg_a        <= 1'b0;
         neg_b        <= 1'b0;
         sgn_q        <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         resp_valid_q <= (state_nxt == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  mcand <= req_a;
                  mplr  <= req_b;
                  acc   <= '0;
                  cnt   <= '0;
`ifdef MUL_SIGNED_EN
                  bop   <= req_b;
                  sgn_q <= req_signed;
                  neg_a <= req_signed & req_a[DATA_WIDTH-1];
                  neg_b <= req_signed & req_b[DATA_WIDTH-1];
`endif
               end
            end
            ST_RUN: begin
               acc  <= {step_c, step_s[DATA_WIDTH-1:1]};
               mplr <= {step_s[0], mplr[DATA_WIDTH-1:1]};
               cnt  <= cnt + CW'(1);
            end
`ifdef MUL_SIGNED_EN
            ST_CORR_A: if (neg_a) acc <= alu_res;
            ST_CORR_B: if (neg_b) acc <= alu_res;
`endif
            default: ;
         endcase
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_hi    = acc;
   assign resp_lo    = mplr;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: vector table plus corner sequences, checked through
// a scoreboard queue filled on request handshake and drained on response.
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_a, req_b;
`ifdef MUL_SIGNED_EN
   logic        req_signed;
`endif
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_hi, resp_lo;

   mul_seq_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
`ifdef MUL_SIGNED_EN
      .req_signed (req_signed),
`endif
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_hi    (resp_hi),
      .resp_lo    (resp_lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a, b;
      logic        sgn;
      logic [31:0] hi, lo;
   } vec_t;

   typedef struct {
      logic [31:0] hi, lo;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t cur_exp;
   exp_t mon_e;
   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pops = 0;
   int   last_acc = 0;
   bit   b2b = 1'b0;
   bit   b2b_first = 1'b0;
   logic rv_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      logic signed [63:0] sp;
      if (sgn) begin
         sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         return sp;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (resp_valid && !rv_prev) begin
            if (sb.size() == 0) chk("spurious_resp", 64'(resp_valid), 64'd0);
            else chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
         end
         if (resp_valid && resp_ready && sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("hi", 64'(resp_hi), 64'(mon_e.hi));
            chk("lo", 64'(resp_lo), 64'(mon_e.lo));
            pops++;
         end
         if (req_valid && req_ready) begin
            if (b2b && !b2b_first) chk("b2b_period", 64'(cyc - last_acc), 64'd34);
            b2b_first = 1'b0;
            last_acc  = cyc;
            mon_e     = cur_exp;
            mon_e.acc_cyc = cyc;
            sb.push_back(mon_e);
         end
      end
      rv_prev = resp_valid;
   end

   task automatic set_req(input vec_t v);
      req_a = v.a;
      req_b = v.b;
`ifdef MUL_SIGNED_EN
      req_signed = v.sgn;
`endif
      cur_exp.hi  = v.hi;
      cur_exp.lo  = v.lo;
      cur_exp.lat = v.sgn ? 35 : 33;
   endtask

   task automatic issue(input vec_t v);
      int n;
      @(posedge clk); #1;
      set_req(v);
      req_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!req_ready && n < 200);
      chk("accept_timeout", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      @(posedge clk);
      @(negedge clk); #1;
      chk("req_ready_after", 64'(req_ready), 64'd1);
      chk("resp_valid_after", 64'(resp_valid), 64'd0);
   endtask

   function automatic vec_t mkv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      vec_t v;
      logic [63:0] p;
      p = model(a, b, sgn);
      v.a = a; v.b = b; v.sgn = sgn; v.hi = p[63:32]; v.lo = p[31:0];
      return v;
   endfunction

   initial begin
      vec_t        v;
      logic [63:0] held;
      int          n;

      tbl.push_back('{32'd3,        32'd5,        1'b0, 32'h00000000, 32'h0000000F});
      tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001});
      tbl.push_back('{32'd7,        32'd6,        1'b0, 32'h00000000, 32'd42});
      tbl.push_back('{32'd0,        32'h12345678, 1'b0, 32'h00000000, 32'h00000000});
      tbl.push_back('{32'h80000000, 32'd2,        1'b0, 32'h00000001, 32'h00000000});
      tbl.push_back('{32'h12345678, 32'h10,       1'b0, 32'h00000001, 32'h23456780});
      tbl.push_back('{32'hFFFFFFFF, 32'd1,        1'b0, 32'h00000000, 32'hFFFFFFFF});
      tbl.push_back('{32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000});
`ifdef MUL_SIGNED_EN
      tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001});
      tbl.push_back('{32'hFFFFFFFE, 32'd3,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA});
      tbl.push_back('{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000});
      tbl.push_back('{32'd5,        32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1});
`endif

      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; resp_ready = 1'b1;
`ifdef MUL_SIGNED_EN
      req_signed = 1'b0;
`endif
      cur_exp = '{32'h0, 32'h0, 33, 0};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_hi", 64'(resp_hi), 64'd0);
      chk("rst_lo", 64'(resp_lo), 64'd0);

      // vector table, consumer always ready
      foreach (tbl[i]) begin
         issue(tbl[i]);
         drain();
      end

      // random operands against the reference model
      for (int i = 0; i < 6; i++) begin
`ifdef MUL_SIGNED_EN
         v = mkv($urandom, $urandom, 1'($urandom_range(0, 1)));
`else
         v = mkv($urandom, $urandom, 1'b0);
`endif
         issue(v);
         drain();
      end

      // backpressure in DONE with a competing request held high
      resp_ready = 1'b0;
      v = mkv(32'h00001234, 32'h00005678, 1'b0);
      held = {v.hi, v.lo};
      issue(v);
      n = 0;
      while (!resp_valid && n < 60) begin
         @(negedge clk); #1;
         n++;
      end
      chk("bp_valid_rise", 64'(resp_valid), 64'd1);
      req_valid = 1'b1; req_a = 32'hAAAA5555; req_b = 32'h0000FFFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         chk("bp_valid_held", 64'(resp_valid), 64'd1);
         chk("bp_prod_held", {resp_hi, resp_lo}, held);
         chk("bp_no_accept", 64'(req_ready), 64'd0);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      resp_ready = 1'b1;
      drain();

      // synchronous reset in the middle of RUN drops the product
      issue(mkv(32'h0000DEAD, 32'h0000BEEF, 1'b0));
      repeat (11) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      @(negedge clk); #1;
      chk("mid_rst_valid", 64'(resp_valid), 64'd0);
      chk("mid_rst_hi", 64'(resp_hi), 64'd0);
      chk("mid_rst_lo", 64'(resp_lo), 64'd0);
      chk("mid_rst_ready", 64'(req_ready), 64'd1);
      issue(mkv(32'd7, 32'd6, 1'b0));
      drain();

      // back-to-back with req_valid tied high and operands changing every cycle
      pops = 0;
      b2b = 1'b1;
      b2b_first = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b1;
      n = 0;
      while (pops < 4 && n < 400) begin
         set_req(mkv($urandom, $urandom, 1'b0));
         @(posedge clk); #1;
         n++;
      end
      chk("b2b_count", 64'(pops), 64'd4);
      req_valid = 1'b0;
      b2b = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
